mont_red_seq: RTL
=================

Name: mont_red_seq

Overview:
- Word-serial Montgomery reduction stage that sits directly downstream of the integer multiplier/MAC.
- Consumes a double-width product T and returns T·R⁻¹ mod q, fully reduced into [0,q), with R = 2^(W·N).
- Iterates over one W-bit word per cycle and reuses a single W×LOGQ multiply.
- Trades throughput for area; valid/ready handshakes on both sides.

Parameters:
- LOGQ, 60, modulus bit width.
- W, 16, reduction word width (bits retired per iteration).
- N, ((LOGQ-1)/W)+1 (derived localparam, not overridable), iteration count.
- LOGT, LOGQ+W*N+1 (derived localparam), width of input T and the internal accumulator.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  T/q/qinv are valid.
- in_ready  output  1  block can accept; high only in IDLE.
- t_in  input  LOGT  product to reduce; caller guarantees t_in ≤ q·R.
- q_in  input  LOGQ  odd modulus.
- qinv_in  input  W  (−q⁻¹) mod 2^W.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- r_out  output  LOGQ  T·R⁻¹ mod q.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE, in_ready=1, out_valid=0, r_out=0.
  - Accumulator, counter and latched q/qinv cleared.
  - An in-flight operation is discarded; nothing is emitted after reset release.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready edge: latch acc←t_in, q←q_in, qinv←qinv_in, cnt←0; go to ITER.
- ITER, one iteration per cycle:
  - m = (acc[W-1:0]·qinv) mod 2^W.
  - acc ← (acc + m·q) >> W; all arithmetic is LOGT+W bits wide, with no truncation before the shift.
  - cnt increments; after the N-th iteration (cnt==N-1) go to FIX.
- FIX:
  - If acc ≥ q then r ← acc − q, else r ← acc; the result is always < q because acc < 2q.
  - Register r_out, set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; r_out held stable while out_ready=0.
  - On out_ready: out_valid←0, go to IDLE. in_ready rises the following cycle; there is no same-cycle accept in DONE.
- Latency: out_valid rises N+1 clock edges after the accepting edge. Throughput is one result per N+3 cycles minimum.
- in_valid outside IDLE is ignored; inputs are not sampled.
- q_in/qinv_in changing mid-operation have no effect because latched copies are used.
- t_in = q·R (boundary) is legal and must yield 0.
- Not checked; caller's responsibility, output undefined if violated:
  - q even.
  - qinv inconsistent with q.
  - t_in > q·R.
- No combinational path from in_valid to out_valid or from out_ready to in_ready.

Test Plan:
(LOGQ=8, W=4, N=2, R=256, q=251, qinv=13)
- t_in=1280 accepted at cycle 0 -> out_valid rises after edge 3, r_out=5, held until out_ready.
- t_in=1 -> r_out=201 (5⁻¹ mod 251); t_in=0 -> r_out=0.
- t_in=64256 (=q·R) -> pre-FIX acc=251, r_out=0; exercises the final-subtract boundary.
- Backpressure: out_ready=0 for 10 cycles with in_valid held high and t_in changed -> r_out stable, in_ready=0, no second capture. After out_ready=1, in_ready=1 next cycle and the new t_in is processed.
- rst pulsed mid-ITER (asynchronous, between edges) -> outputs return to reset values immediately. No out_valid for the aborted operation. Next op t_in=1280 -> 5.
- Randomised 10k ops, LOGQ=60/W=16 and LOGQ=8/W=4: random odd q, t_in=a·b with a,b<q -> r_out equals a golden model of a·b·R⁻¹ mod q; latency is always N+1.

Source files
------------

// File: rtl/mont_red_seq.sv
`timescale 1ns/1ps
// mont_red_seq: word-serial Montgomery reduction, r_out = t_in * 2^(-W*N) mod q.
// One W-bit word of the accumulator is retired per ITER cycle using a single
// W x LOGQ multiply; a final conditional subtract brings the result into [0,q).
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// ITER  | one reduction word per cycle, N cycles
// FIX   | conditional subtract of q, result registered
// DONE  | result presented, held until out_ready
module mont_red_seq #(
  parameter  int LOGQ = 60,
  parameter  int W    = 16,
  localparam int N    = ((LOGQ - 1) / W) + 1,
  localparam int LOGT = LOGQ + W * N + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGT-1:0] t_in,
  input  logic [LOGQ-1:0] q_in,
  input  logic [W-1:0]    qinv_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] r_out
);

  localparam int AW = LOGT + W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LOGT-1:0] acc;
  logic [LOGQ-1:0] q_r;
  logic [W-1:0]    qinv_r;
  logic [CW-1:0]   cnt;

  logic            do_load, do_iter, do_fix, do_release;
  logic [W-1:0]    m;
  logic [AW-1:0]   sum;
  logic [LOGT-1:0] acc_next;
  logic [LOGQ-1:0] r_fix;

  assign in_ready = (state_q == IDLE);

  // Reduction datapath: the sum is kept full width so nothing is lost before the shift.
  always_comb begin
    m        = acc[W-1:0] * qinv_r;
    sum      = AW'(acc) + AW'(m) * AW'(q_r);
    acc_next = LOGT'(sum >> W);
    if (acc >= LOGT'(q_r))
      r_fix = LOGQ'(acc - LOGT'(q_r));
    else
      r_fix = LOGQ'(acc);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_d    = state_q;
    do_load    = 1'b0;
    do_iter    = 1'b0;
    do_fix     = 1'b0;
    do_release = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          do_load = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        do_iter = 1'b1;
        if (cnt == CNT_LAST)
          state_d = FIX;
      end
      FIX: begin
        do_fix  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latches, accumulator, iteration counter and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      q_r       <= '0;
      qinv_r    <= '0;
      cnt       <= '0;
      r_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (do_load) begin
        acc    <= t_in;
        q_r    <= q_in;
        qinv_r <= qinv_in;
        cnt    <= '0;
      end
      if (do_iter) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (do_fix) begin
        r_out     <= r_fix;
        out_valid <= 1'b1;
      end
      if (do_release)
        out_valid <= 1'b0;
    end
  end

endmodule
